// File: rtl/leaf_kernel_bridge.sv
// leaf_kernel_bridge: elastic bridge between the leaf_interface user side and an
// HLS kernel with ap_vld/ap_ack streams and ap_ctrl_hs run control. Every stream
// passes through a first-word-fall-through FIFO; a small FSM issues ap_start.

// Per-channel FWFT FIFO. Accept is a registered copy of "not full" so that it is
// low while in reset and rises on the first clock after reset is released.
module leaf_kernel_bridge_fifo #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 wr_vld,
  output logic                 wr_ack,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_vld,
  input  logic                 rd_ack,
  output logic [ADDR_BITS:0]   level
);
  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL_LEVEL = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0] LVL_ONE    = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   level_q;
  logic [ADDR_BITS:0]   level_d;
  logic                 ack_q;
  logic                 wr_en;
  logic                 rd_en;

  assign wr_en   = wr_vld & ack_q;
  assign rd_vld  = (level_q != '0);
  assign rd_en   = rd_vld & rd_ack;
  assign wr_ack  = ack_q;
  assign rd_data = mem[rd_ptr];
  assign level   = level_q;

  // Next occupancy; a clear wins over any concurrent write or read.
  always_comb begin
    level_d = level_q;
    if (clear) begin
      level_d = '0;
    end else if (wr_en && !rd_en) begin
      level_d = level_q + LVL_ONE;
    end else if (!wr_en && rd_en) begin
      level_d = level_q - LVL_ONE;
    end
  end

  // Pointers, occupancy and the registered accept flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      ack_q   <= (level_d != FULL_LEVEL);
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
        if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage; zeroed on reset so the fall-through data output reads 0 in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && !clear) begin
      mem[wr_ptr] <= wr_data;
    end
  end
endmodule

module leaf_kernel_bridge #(
  parameter int unsigned NUM_IN_PORTS    = 1,
  parameter int unsigned NUM_OUT_PORTS   = 1,
  parameter int unsigned PAYLOAD_BITS    = 32,
  parameter int unsigned FIFO_DEPTH_BITS = 2,
  parameter int unsigned AUTO_START      = 0
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        flush,
  input  logic                                        ap_start,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]        dout_leaf_interface2user,
  input  logic [NUM_IN_PORTS-1:0]                     vld_interface2user,
  output logic [NUM_IN_PORTS-1:0]                     ack_user2interface,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]       din_leaf_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                    vld_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                    ack_interface2user,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]        k_in_data,
  output logic [NUM_IN_PORTS-1:0]                     k_in_vld,
  input  logic [NUM_IN_PORTS-1:0]                     k_in_ack,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]       k_out_data,
  input  logic [NUM_OUT_PORTS-1:0]                    k_out_vld,
  output logic [NUM_OUT_PORTS-1:0]                    k_out_ack,
  output logic                                        k_ap_start,
  input  logic                                        k_ap_ready,
  input  logic                                        k_ap_done,
  output logic                                        busy,
  output logic [15:0]                                 run_count,
  output logic [NUM_IN_PORTS*(FIFO_DEPTH_BITS+1)-1:0] in_level
);
  localparam int unsigned LW = FIFO_DEPTH_BITS + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       fifo_clear;
  logic       go;
  logic       run_done;
  logic       auto_en;

  assign fifo_clear = flush & (state_q == ST_IDLE);
  assign auto_en    = (AUTO_START != 0);
  assign go         = ap_start | (auto_en & (&k_in_vld));

  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
    leaf_kernel_bridge_fifo #(
      .WIDTH     (PAYLOAD_BITS),
      .ADDR_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .clear   (fifo_clear),
      .wr_data (dout_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .wr_vld  (vld_interface2user[i]),
      .wr_ack  (ack_user2interface[i]),
      .rd_data (k_in_data[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_vld  (k_in_vld[i]),
      .rd_ack  (k_in_ack[i]),
      .level   (in_level[i*LW +: LW])
    );
  end

  for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out
    logic [LW-1:0] out_level;
    leaf_kernel_bridge_fifo #(
      .WIDTH     (PAYLOAD_BITS),
      .ADDR_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .clear   (fifo_clear),
      .wr_data (k_out_data[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .wr_vld  (k_out_vld[j]),
      .wr_ack  (k_out_ack[j]),
      .rd_data (din_leaf_user2interface[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .rd_vld  (vld_user2interface[j]),
      .rd_ack  (ack_interface2user[j]),
      .level   (out_level)
    );
  end

  // Run-control next state; ready and done together in START finish the run at once.
  always_comb begin
    state_d  = state_q;
    run_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go && !flush) state_d = ST_START;
      end
      ST_START: begin
        if (k_ap_ready) begin
          if (k_ap_done) begin
            state_d  = ST_IDLE;
            run_done = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (k_ap_done) begin
          state_d  = ST_IDLE;
          run_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and saturating completed-run counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      run_count <= '0;
    end else begin
      state_q <= state_d;
      if (run_done && (run_count != '1)) begin
        run_count <= run_count + 16'd1;
      end
    end
  end

  assign k_ap_start = (state_q == ST_START);
  assign busy       = (state_q != ST_IDLE);
endmodule

// File: doc/leaf_kernel_bridge.md
Name: leaf_kernel_bridge

Overview:
- Parametrised bridge between the user side of leaf_interface and an HLS kernel that uses ap_vld/ap_ack streams and ap_ctrl_hs control.
- Replaces direct leaf-to-kernel wiring. Adds per-channel elastic FIFOs on every input and output stream, and a run-control FSM that issues ap_start manually or automatically.
- Reports run count and per-channel occupancy for debug.

Parameters:
- NUM_IN_PORTS, 1, number of interface-to-kernel streams.
- NUM_OUT_PORTS, 1, number of kernel-to-interface streams.
- PAYLOAD_BITS, 32, data width per stream.
- FIFO_DEPTH_BITS, 2, log2 of FIFO depth per channel (depth 4 at default).
- AUTO_START, 0, 1 = start a run automatically when every input FIFO is non-empty.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all FIFOs; allowed only while the FSM is in IDLE.
- ap_start  in  1  external run request; level-sensitive.
- dout_leaf_interface2user  in  NUM_IN_PORTS*PAYLOAD_BITS  packed input data, channel i at bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- vld_interface2user  in  NUM_IN_PORTS  input valid.
- ack_user2interface  out  NUM_IN_PORTS  input accept.
- din_leaf_user2interface  out  NUM_OUT_PORTS*PAYLOAD_BITS  packed output data.
- vld_user2interface  out  NUM_OUT_PORTS  output valid.
- ack_interface2user  in  NUM_OUT_PORTS  output accept.
- k_in_data  out  NUM_IN_PORTS*PAYLOAD_BITS  kernel Input_*_V_V.
- k_in_vld  out  NUM_IN_PORTS  kernel Input ap_vld.
- k_in_ack  in  NUM_IN_PORTS  kernel Input ap_ack.
- k_out_data  in  NUM_OUT_PORTS*PAYLOAD_BITS  kernel Output_*_V_V.
- k_out_vld  in  NUM_OUT_PORTS  kernel Output ap_vld.
- k_out_ack  out  NUM_OUT_PORTS  kernel Output ap_ack.
- k_ap_start  out  1  kernel ap_start.
- k_ap_ready  in  1  kernel ap_ready.
- k_ap_done  in  1  kernel ap_done.
- busy  out  1  FSM not in IDLE.
- run_count  out  16  completed runs, saturating at 0xFFFF.
- in_level  out  NUM_IN_PORTS*(FIFO_DEPTH_BITS+1)  input FIFO occupancy.

Behaviour:
- Transfer rule: a word moves on a port in any cycle where its valid and accept signals are both high. Applies to vld/ack and ap_vld/ap_ack alike.
- Reset (reset=0, asynchronous):
  - FIFOs empty; FSM in IDLE; run_count=0.
  - k_ap_start=0, busy=0, all vld outputs 0.
  - ack_user2interface and k_out_ack are 0 during reset, then 1 from the first cycle after reset deassertion (FIFOs empty).
  - Data outputs are 0.
- Input FIFO i:
  - ack_user2interface[i] = !full_i.
  - k_in_vld[i] = !empty_i; k_in_data shows the head word combinationally from storage (first-word fall-through).
  - Write and read in the same cycle while full: the read frees a slot, but the ack is already low, so no write occurs. Simultaneous write and read while empty cannot happen, because vld is low when empty.
  - Occupancy is a FIFO_DEPTH_BITS+1 bit counter. Read/write pointers wrap modulo depth.
- Output FIFO j: mirror image. k_out_ack[j] = !full_j; vld_user2interface[j] = !empty_j.
- Latency: 1 cycle from a write to visibility at the far side, with a registered empty flag. Throughput is 1 word per cycle per channel when both sides are ready.
- Run-control FSM:
  - IDLE:
    - go = ap_start | (AUTO_START & all input FIFOs non-empty).
    - If go & !flush, move to START next cycle.
  - START:
    - k_ap_start=1.
    - On k_ap_ready=1: move to RUN, or to IDLE if k_ap_done=1 in the same cycle. In that case run_count increments once.
  - RUN:
    - k_ap_start=0.
    - On k_ap_done=1: increment run_count (saturating), move to IDLE.
  - busy = (state != IDLE).
  - k_ap_done is ignored in IDLE.
- flush:
  - In IDLE it clears pointers and levels of all FIFOs in one cycle. Flush has priority over a concurrent write, and the word is dropped.
  - In START or RUN, flush is ignored.
- Reset mid-run: the FSM returns to IDLE immediately, FIFO contents are discarded, and run_count clears.
- Width rules: packed buses are indexed channel-major; no per-channel width variation.

Test Plan:
- Single word, defaults: push 0xDEADBEEF on input 0 with k_in_ack=1 -> k_in_vld high 1 cycle after acceptance with data 0xDEADBEEF; level returns to 0.
- Backpressure: k_in_ack=0, drive vld continuously -> ack_user2interface drops after exactly 4 accepted words. Then k_in_ack=1 -> words leave in order 1,2,3,4 and ack rises again.
- Manual run: pulse ap_start; kernel ready after 3 cycles, done after 10 more -> k_ap_start high until the ready cycle; busy high throughout; run_count=1.
- AUTO_START=1, NUM_IN_PORTS=2: fill only channel 0 -> FSM stays in IDLE. Fill channel 1 -> START next cycle. Ready and done in the same cycle -> IDLE, run_count=1.
- Output path, NUM_OUT_PORTS=2: kernel writes 0x11 to channel 0 and 0x22 to channel 1 with ack_interface2user=0 -> both vld high with the correct data lanes. Release channel 1 only -> only 0x22 drains.
- Flush and reset: 3 words queued, flush in IDLE -> level 0, k_in_vld=0. Assert reset during RUN -> k_ap_start=0, busy=0, run_count=0 asynchronously.
